// File: rtl/count_snapshot_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_snapshot_fifo_pkg
// Purpose  : Shared widths and entry layout for the count snapshot FIFO.
//            A captured entry is {epoch, count}. The count occupies the low
//            COUNT_W bits and the epoch sits directly above it.
// Revision : 1.0 - initial release
// ============================================================================
package count_snapshot_fifo_pkg;

    localparam int c_COUNT_W   = 4;                      // upstream count width
    localparam int c_EPOCH_W   = 4;                      // wrap counter width
    localparam int c_DEPTH     = 8;                      // FIFO entries (power of 2, >= 2)
    localparam int c_ENTRY_W   = c_EPOCH_W + c_COUNT_W;  // one stored timestamp

    // Entry field positions
    localparam int c_COUNT_LSB = 0;
    localparam int c_EPOCH_LSB = c_COUNT_W;

endpackage : count_snapshot_fifo_pkg
`default_nettype wire

// File: rtl/count_snapshot_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : count_snapshot_fifo_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. Full and empty come
//            from the level counter, so the pointers can wrap naturally.
//            A write is accepted when not full, or when full and a pop
//            happens on the same edge. A rejected write is flagged on 'drop'.
// Ports    : clk, reset (async, active-high)
//            wr_req, wr_data      write request and data
//            rd_ready             consumer accepts the head entry
//            rd_data, rd_valid    head entry (FWFT) and non-empty flag
//            level                entry count, 0..DEPTH
//            drop                 wr_req was rejected this cycle
// Revision : 1.0 - initial release
// ============================================================================
module count_snapshot_fifo_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_level == c_LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && rd_ready;
    // A pop frees a slot on the same edge, so a full FIFO can still take a write.
    assign w_push  = wr_req && (!w_full || w_pop);
    assign drop    = wr_req && !w_push;

    // Storage carries no reset: contents are meaningless while level is 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head entry falls through from storage; no write-to-read bypass.
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
    assign level    = r_level;

endmodule : count_snapshot_fifo_sync_fifo
`default_nettype wire

// File: rtl/count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : count_snapshot_fifo
// Purpose  : Watches a free-running upstream counter, counts its wrap-arounds
//            in an epoch register and, on every trigger cycle, queues an
//            {epoch, count} timestamp for a downstream valid/ready reader.
// Ports    : clk, reset (async, active-high)
//            count                 upstream counter value
//            trigger               capture request (one capture per high cycle)
//            out_data, out_valid   head timestamp and non-empty flag
//            out_ready             reader accepts the head entry
//            level                 entries held, 0..DEPTH
//            epoch                 current wrap counter
//            overflow, ovf_clr     sticky dropped-capture flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module count_snapshot_fifo
    import count_snapshot_fifo_pkg::*;
#(
    parameter int COUNT_W = c_COUNT_W,
    parameter int EPOCH_W = c_EPOCH_W,
    parameter int DEPTH   = c_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [COUNT_W-1:0]          count,
    input  logic                        trigger,
    output logic [EPOCH_W+COUNT_W-1:0]  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic [EPOCH_W-1:0]          epoch,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int c_ENTRY_W = EPOCH_W + COUNT_W;

    logic [COUNT_W-1:0]   r_prev_count;
    logic [EPOCH_W-1:0]   r_epoch;
    logic                 r_overflow;

    logic                 w_wrap;
    logic [EPOCH_W-1:0]   w_cap_epoch;
    logic [c_ENTRY_W-1:0] w_entry;
    logic                 w_drop;

    // A wrap is the all-ones -> zero transition. An upstream reset taken
    // exactly at all-ones is indistinguishable and is counted as a wrap.
    assign w_wrap = (count == '0) && (r_prev_count == {COUNT_W{1'b1}});

    // On the wrap cycle the count already reads 0, so the captured epoch
    // must already include this wrap to stay consistent with it.
    assign w_cap_epoch = r_epoch + EPOCH_W'(w_wrap);

    assign w_entry[COUNT_W-1:0]         = count;
    assign w_entry[c_ENTRY_W-1:COUNT_W] = w_cap_epoch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= '0;
            r_epoch      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_count <= count;
            r_epoch      <= w_cap_epoch;
            // A fresh drop outranks a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    count_snapshot_fifo_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (trigger),
        .wr_data  (w_entry),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .level    (level),
        .drop     (w_drop)
    );

    assign epoch    = r_epoch;
    assign overflow = r_overflow;

endmodule : count_snapshot_fifo
`default_nettype wire

// File: tb/tb_count_snapshot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_snapshot_fifo
// Purpose  : Randomized bench for count_snapshot_fifo. A queue-based model
//            tracks expected timestamps; a monitor compares each popped head
//            entry against the queue while the stimulus task checks level,
//            valid, epoch and overflow after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_snapshot_fifo;

    localparam int COUNT_W = 4;
    localparam int EPOCH_W = 4;
    localparam int DEPTH   = 8;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [COUNT_W-1:0]         count;
    logic                       trigger;
    logic [EPOCH_W+COUNT_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [LVL_W-1:0]           level;
    logic [EPOCH_W-1:0]         epoch;
    logic                       overflow;
    logic                       ovf_clr;

    count_snapshot_fifo #(
        .COUNT_W (COUNT_W),
        .EPOCH_W (EPOCH_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .trigger   (trigger),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .epoch     (epoch),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] sb_q [$];
    int         m_level;
    logic [3:0] m_epoch;
    logic [3:0] m_prev;
    bit         m_ovf;
    logic [3:0] cur_cnt;
    logic [7:0] mon_exp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"},     int'(level),     m_level);
        check({tag, "_out_valid"}, int'(out_valid), (m_level > 0) ? 1 : 0);
        check({tag, "_epoch"},     int'(epoch),     int'(m_epoch));
        check({tag, "_overflow"},  int'(overflow),  int'(m_ovf));
    endtask

    // Monitor: every accepted head entry must be the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%02h required=<no entry>", out_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (out_data !== mon_exp) begin
                    failures++;
                    $display("FAIL out_data actual=%02h required=%02h at %0t",
                             out_data, mon_exp, $time);
                end
            end
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input bit trig, input bit rdy, input bit clr, input logic [3:0] cnt);
        bit         wrap;
        bit         pop;
        bit         push;
        logic [3:0] ep;
        trigger   = trig;
        out_ready = rdy;
        ovf_clr   = clr;
        count     = cnt;
        wrap = (cnt == 4'd0) && (m_prev == 4'hF);
        ep   = m_epoch + {3'b000, wrap};
        pop  = (m_level > 0) && rdy;
        push = trig && ((m_level < DEPTH) || pop);
        if (push) sb_q.push_back({ep, cnt});
        m_level = m_level + int'(push) - int'(pop);
        m_epoch = ep;
        m_prev  = cnt;
        if (trig && !push) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_status("step");
    endtask

    // Mostly counts up; occasionally jumps (including upstream resets to 0).
    function automatic logic [3:0] next_cnt(input logic [3:0] c);
        if ($urandom_range(0, 19) == 0) return 4'($urandom_range(0, 15));
        return c + 4'd1;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_level = 0;
        m_epoch = 4'd0;
        m_prev  = 4'd0;
        m_ovf   = 1'b0;
    endtask

    task automatic run_random(input int n, input int p_trig, input int p_rdy, input int p_clr);
        for (int i = 0; i < n; i++) begin
            cur_cnt = next_cnt(cur_cnt);
            step($urandom_range(0, 99) < p_trig, $urandom_range(0, 99) < p_rdy,
                 $urandom_range(0, 99) < p_clr, cur_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; count = '0;
        model_reset();
        #1;
        check_status("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Counts 0..5, one capture at count 3 -> 8'h03 read immediately.
        for (int i = 0; i < 6; i++) step(i == 3, 1'b1, 1'b0, 4'(i));
        cur_cnt = 4'd5;

        // Through a wrap (15 -> 0) with captures on the wrap and later at 5.
        for (int i = 6; i < 22; i++) begin
            cur_cnt = 4'(i);
            step((cur_cnt == 4'd0) || (cur_cnt == 4'd5), 1'b1, 1'b0, cur_cnt);
        end

        // Fill with the reader stalled: 10 triggers, drops set overflow.
        for (int i = 0; i < 10; i++) begin
            cur_cnt = cur_cnt + 4'd1;
            step(1'b1, 1'b0, 1'b0, cur_cnt);
        end
        // Clear together with a drop: set wins; then clear alone.
        cur_cnt = cur_cnt + 4'd1; step(1'b1, 1'b0, 1'b1, cur_cnt);
        cur_cnt = cur_cnt + 4'd1; step(1'b0, 1'b0, 1'b1, cur_cnt);
        // Full with trigger and pop: accepted, level stays full.
        for (int i = 0; i < 4; i++) begin
            cur_cnt = cur_cnt + 4'd1;
            step(1'b1, 1'b1, 1'b0, cur_cnt);
        end

        run_random(400, 50, 50, 10);
        run_random(200, 90, 20, 5);

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_status("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 4'd2);
        cur_cnt = 4'd2;

        run_random(300, 60, 80, 10);

        // Drain
        for (int i = 0; i < DEPTH + 2; i++) begin
            cur_cnt = next_cnt(cur_cnt);
            step(1'b0, 1'b1, 1'b0, cur_cnt);
        end
        check("drain_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_count_snapshot_fifo
`default_nettype wire
